// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259-style INTA sequencer with in-service register, EOI/AEOI and vector generation
// Ports: clk/rst (sync active-high); irr/imr request and mask; inta CPU acknowledge level;
// eoi non-specific EOI strobe; ar auto-EOI enable; rot rotate-on-EOI; icw2_wr/icw2 vector base load;
// int_o CPU interrupt; vec_o/vec_valid vector byte and strobe; isr_o in-service; state_o debug state.
// Optional feature: define PIC_ROTATE_EN for rotating priority (rot_ptr marks the lowest-priority level).
module pic_inta_sequencer #(
  parameter logic [4:0] VEC_BASE_RST = 5'h01,
  parameter logic [2:0] SPUR_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta,
  input  logic       eoi,
  input  logic       ar,
  input  logic       rot,
  input  logic       icw2_wr,
  input  logic [4:0] icw2,
  output logic       int_o,
  output logic [7:0] vec_o,
  output logic       vec_valid,
  output logic [7:0] isr_o,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, PEND = 2'b01, ACK1 = 2'b10} state_t;
  state_t state, state_nx;
  logic inta_q, inta_rise, spur, has_win, eoi_hit, latch, fire, aeoi;
  logic [2:0] lvl, rot_ptr, sh, win_lvl, eoi_lvl;
  logic [3:0] r_elig, r_isr;
  logic [4:0] vec_base;
  logic [7:0] isr, set_m, clr_m;
  function automatic logic [3:0] first_set(input logic [7:0] v);
    first_set = 4'd8;
    for (int i = 7; i >= 0; i--) if (v[i]) first_set = 4'(i);
  endfunction
  // Rotate so that rank 0 is the highest-priority level (rot_ptr+1).
  function automatic logic [7:0] rot_r(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] d;
    d = {v, v} >> s;
    return d[7:0];
  endfunction
`ifdef PIC_ROTATE_EN
  always_ff @(posedge clk)
    if (rst) rot_ptr <= 3'd7;
    else if (aeoi && rot) rot_ptr <= lvl;
    else if (eoi_hit && rot) rot_ptr <= eoi_lvl;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign rot_ptr = 3'd7;
`endif
  assign sh = rot_ptr + 3'd1;
  assign r_elig = first_set(rot_r(irr & ~imr, sh));
  assign r_isr = first_set(rot_r(isr, sh));
  assign has_win = r_elig < r_isr;
  assign win_lvl = r_elig[2:0] + sh;
  assign eoi_lvl = r_isr[2:0] + sh;
  assign eoi_hit = eoi && !r_isr[3];
  assign inta_rise = inta && !inta_q;
  always_comb begin
    state_nx = state;
    latch = 1'b0;
    fire = 1'b0;
    aeoi = 1'b0;
    case (state)
      IDLE: state_nx = has_win ? PEND : IDLE;
      PEND: begin
        latch = inta_rise;
        state_nx = inta_rise ? ACK1 : PEND;
      end
      ACK1: begin
        fire = inta_rise;
        aeoi = inta_rise && ar && !spur;
        state_nx = inta_rise ? IDLE : ACK1;
      end
      default: state_nx = IDLE;
    endcase
    set_m = (latch && has_win) ? 8'h01 << win_lvl : 8'h00;
    clr_m = (eoi_hit ? 8'h01 << eoi_lvl : 8'h00) | (aeoi ? 8'h01 << lvl : 8'h00);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      inta_q <= 1'b0;
      isr <= 8'h00;
      vec_o <= 8'h00;
      vec_valid <= 1'b0;
      vec_base <= VEC_BASE_RST;
      lvl <= 3'd0;
      spur <= 1'b0;
    end else begin
      inta_q <= inta;
      isr <= (isr & ~clr_m) | set_m;
      vec_valid <= fire;
      if (fire) vec_o <= {vec_base, lvl};
      if (icw2_wr) vec_base <= icw2;
      if (latch) begin
        lvl <= has_win ? win_lvl : SPUR_LEVEL;
        spur <= !has_win;
      end
    end
  assign int_o = state == PEND;
  assign isr_o = isr;
  assign state_o = state;
endmodule
